// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, synchronous-read instruction memory and a two-register
// output pipeline with valid/ready handshake, redirect and decoded field slices.
module instr_fetch #(
  parameter int unsigned     WIDTH    = 32,
  parameter int unsigned     DEPTH    = 64,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                     iClk,
  input  logic                     iRstN,
  input  logic                     iWrEn,
  input  logic [$clog2(DEPTH)-1:0] iWrAddr,
  input  logic [WIDTH-1:0]         iWrData,
  input  logic                     iRedirect,
  input  logic [WIDTH-1:0]         iRedirectPC,
  input  logic                     iReady,
  output logic                     oValid,
  output logic [WIDTH-1:0]         oInstr,
  output logic [WIDTH-1:0]         oPC,
  output logic [6:0]               oOpcode,
  output logic [4:0]               oRD,
  output logic [2:0]               oFunct3,
  output logic [4:0]               oRS1,
  output logic [4:0]               oRS2,
  output logic [6:0]               oFunct7
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic [WIDTH-1:0] rpc_q, rpc_d;
  logic             rvalid_q, rvalid_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0] opc_q, opc_d;
  logic             valid_q, valid_d;
  logic             advance;
  logic [AW-1:0]    rd_idx;
  logic             unused_bits;

  assign unused_bits = ^iRedirectPC[1:0];

  // Word index wraps modulo DEPTH; the full PC still travels with the data.
  assign rd_idx  = pc_q[AW+1:2];
  assign advance = !valid_q || iReady;

  // Writes are not gated by reset so boot logic can load the program while the core is held.
  always_ff @(posedge iClk) begin
    if (iWrEn) begin
      mem[iWrAddr] <= iWrData;
    end
  end

  always_comb begin
    pc_d     = pc_q;
    rdata_d  = rdata_q;
    rpc_d    = rpc_q;
    rvalid_d = rvalid_q;
    instr_d  = instr_q;
    opc_d    = opc_q;
    valid_d  = valid_q;
    if (iRedirect) begin
      pc_d     = {iRedirectPC[WIDTH-1:2], 2'b00};
      rvalid_d = 1'b0;
      valid_d  = 1'b0;
    end else if (advance) begin
      // mem is sampled before this edge's write lands, giving read-before-write on collision.
      rdata_d  = mem[rd_idx];
      rpc_d    = pc_q;
      rvalid_d = 1'b1;
      pc_d     = pc_q + WIDTH'(4);
      instr_d  = rdata_q;
      opc_d    = rpc_q;
      valid_d  = rvalid_q;
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      pc_q     <= RESET_PC;
      rdata_q  <= '0;
      rpc_q    <= '0;
      rvalid_q <= 1'b0;
      instr_q  <= '0;
      opc_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      rdata_q  <= rdata_d;
      rpc_q    <= rpc_d;
      rvalid_q <= rvalid_d;
      instr_q  <= instr_d;
      opc_q    <= opc_d;
      valid_q  <= valid_d;
    end
  end

  assign oValid  = valid_q;
  assign oInstr  = instr_q;
  assign oPC     = opc_q;
  assign oOpcode = instr_q[6:0];
  assign oRD     = instr_q[11:7];
  assign oFunct3 = instr_q[14:12];
  assign oRS1    = instr_q[19:15];
  assign oRS2    = instr_q[24:20];
  assign oFunct7 = instr_q[31:25];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch: latency, stall, redirect, wrap, reset, collision.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ready;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;

  int checks;
  int errors;

  instr_fetch #(
    .WIDTH(32),
    .DEPTH(64),
    .RESET_PC(32'h0)
  ) dut (
    .iClk       (clk),
    .iRstN      (rst_n),
    .iWrEn      (wr_en),
    .iWrAddr    (wr_addr),
    .iWrData    (wr_data),
    .iRedirect  (redirect),
    .iRedirectPC(redirect_pc),
    .iReady     (ready),
    .oValid     (valid),
    .oInstr     (instr),
    .oPC        (pc),
    .oOpcode    (opcode),
    .oRD        (rd),
    .oFunct3    (funct3),
    .oRS1       (rs1),
    .oRS2       (rs2),
    .oFunct7    (funct7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program image loaded at reset.
  function automatic logic [31:0] init_word(input int i);
    case (i)
      0:       return 32'h0050_0093;
      1:       return 32'h00A0_0113;
      2:       return 32'h0020_81B3;
      3:       return 32'h4020_8233;
      default: return 32'h1000_0000 | 32'(i);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
    for (int i = 0; i < 64; i++) begin
      wr_en = 1'b1; wr_addr = 6'(i); wr_data = init_word(i);
      tick();
    end
    wr_en = 1'b0;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 0", instr); end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", pc); end
    checks++; if (opcode !== 7'h0 || funct7 !== 7'h0) begin
      errors++; $display("FAIL reset_fields got %h/%h want 0/0", opcode, funct7);
    end
    rst_n = 1'b1;
    tick();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL latency_e0 got %b want 0", valid); end
    tick();
    checks++; if (valid !== 1'b1 || pc !== 32'h0 || instr !== 32'h0050_0093) begin
      errors++; $display("FAIL latency_first got v=%b pc=%h i=%h want v=1 pc=0 i=00500093",
                         valid, pc, instr);
    end
  endtask

  task automatic test_stall();
    tick();
    checks++; if (pc !== 32'h4) begin errors++; $display("FAIL seq_pc4 got %h want 4", pc); end
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (valid !== 1'b1 || pc !== 32'h4 || instr !== 32'h00A0_0113) begin
        errors++; $display("FAIL stall_hold got v=%b pc=%h i=%h want v=1 pc=4 i=00a00113",
                           valid, pc, instr);
      end
    end
    ready = 1'b1;
    tick();
    checks++; if (valid !== 1'b1 || pc !== 32'h8 || instr !== 32'h0020_81B3) begin
      errors++; $display("FAIL stall_release got v=%b pc=%h i=%h want v=1 pc=8 i=002081b3",
                         valid, pc, instr);
    end
    checks++; if (opcode !== 7'h33 || rd !== 5'd3 || rs1 !== 5'd1 || rs2 !== 5'd2 ||
                  funct3 !== 3'd0 || funct7 !== 7'h00) begin
      errors++; $display("FAIL fields_add got op=%h rd=%0d rs1=%0d rs2=%0d f3=%0d f7=%h",
                         opcode, rd, rs1, rs2, funct3, funct7);
    end
    tick();
    checks++; if (pc !== 32'hC || instr !== 32'h4020_8233 || funct7 !== 7'h20) begin
      errors++; $display("FAIL fields_sub got pc=%h i=%h f7=%h want pc=c i=40208233 f7=20",
                         pc, instr, funct7);
    end
  endtask

  task automatic test_redirect();
    ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h22;
    tick();
    redirect = 1'b0;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL redir_flush got %b want 0", valid); end
    tick();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL redir_bubble got %b want 0", valid); end
    tick();
    checks++; if (valid !== 1'b1 || pc !== 32'h20 || instr !== init_word(8)) begin
      errors++; $display("FAIL redir_target got v=%b pc=%h i=%h want v=1 pc=20 i=%h",
                         valid, pc, instr, init_word(8));
    end
    ready = 1'b1;
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_pc = 32'hF8;
    tick();
    redirect = 1'b0;
    tick();
    tick();
    checks++; if (pc !== 32'hF8 || instr !== init_word(62)) begin
      errors++; $display("FAIL wrap_f8 got pc=%h i=%h want pc=f8 i=%h", pc, instr, init_word(62));
    end
    tick();
    checks++; if (pc !== 32'hFC) begin errors++; $display("FAIL wrap_fc got %h want fc", pc); end
    tick();
    checks++; if (valid !== 1'b1 || pc !== 32'h100 || instr !== init_word(0)) begin
      errors++; $display("FAIL wrap_100 got v=%b pc=%h i=%h want v=1 pc=100 i=%h",
                         valid, pc, instr, init_word(0));
    end
    tick();
    checks++; if (pc !== 32'h104 || instr !== init_word(1)) begin
      errors++; $display("FAIL wrap_104 got pc=%h i=%h want pc=104 i=%h", pc, instr, init_word(1));
    end
  endtask

  task automatic test_reset_mid();
    redirect = 1'b1; redirect_pc = 32'hC;
    tick();
    redirect = 1'b0;
    tick();
    tick();
    checks++; if (pc !== 32'hC) begin errors++; $display("FAIL mid_setup got %h want c", pc); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (valid !== 1'b0 || pc !== 32'h0 || instr !== 32'h0) begin
      errors++; $display("FAIL mid_reset got v=%b pc=%h i=%h want v=0 pc=0 i=0", valid, pc, instr);
    end
    tick();
    tick();
    checks++; if (valid !== 1'b1 || pc !== 32'h0 || instr !== init_word(0)) begin
      errors++; $display("FAIL mid_restart got v=%b pc=%h i=%h want v=1 pc=0 i=%h",
                         valid, pc, instr, init_word(0));
    end
    // Reset beats a simultaneous redirect.
    rst_n = 1'b0; redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    rst_n = 1'b1; redirect = 1'b0;
    tick();
    tick();
    checks++; if (valid !== 1'b1 || pc !== 32'h0) begin
      errors++; $display("FAIL rst_vs_redir got v=%b pc=%h want v=1 pc=0", valid, pc);
    end
  endtask

  task automatic test_collision();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    checks++; if (pc !== 32'h0 || valid !== 1'b1) begin
      errors++; $display("FAIL coll_setup got v=%b pc=%h want v=1 pc=0", valid, pc);
    end
    wr_en = 1'b1; wr_addr = 6'd2; wr_data = 32'hDEAD_BEEF;
    tick();
    wr_en = 1'b0;
    tick();
    checks++; if (pc !== 32'h8 || instr !== 32'h0020_81B3) begin
      errors++; $display("FAIL coll_old got pc=%h i=%h want pc=8 i=002081b3", pc, instr);
    end
    redirect = 1'b1; redirect_pc = 32'h8;
    tick();
    redirect = 1'b0;
    tick();
    tick();
    checks++; if (valid !== 1'b1 || pc !== 32'h8 || instr !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL coll_new got v=%b pc=%h i=%h want v=1 pc=8 i=deadbeef",
                         valid, pc, instr);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    redirect = 1'b0; redirect_pc = '0; ready = 1'b1;
    test_reset();
    test_stall();
    test_redirect();
    test_wrap();
    test_reset_mid();
    test_collision();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch stage for the single-issue core. It holds the program counter and an on-chip synchronous-read instruction memory, and presents one instruction per cycle to the register-select/decode stage through a valid/ready handshake. It splits the instruction into opcode/rd/funct3/rs1/rs2/funct7 for the downstream register select and ALU. It accepts a redirect from the execute stage for branches and jumps, and has a write port so benches and boot logic can load the program.

Parameters:
WIDTH, 32, data/PC width; fixed at 32 because the field slicing depends on it.
DEPTH, 64, instruction memory depth in 32-bit words; power of two.
RESET_PC, 0, PC value loaded on reset; word aligned.

Ports:
iClk  input  1  clock, rising edge
iRstN  input  1  synchronous reset, active low
iWrEn  input  1  instruction memory write enable
iWrAddr  input  log2(DEPTH)  memory write word index
iWrData  input  WIDTH  memory write data
iRedirect  input  1  flush and redirect fetch
iRedirectPC  input  WIDTH  redirect target; bits [1:0] ignored
iReady  input  1  decode stage can accept the current output
oValid  output  1  oInstr/oPC hold a valid instruction
oInstr  output  WIDTH  fetched instruction
oPC  output  WIDTH  byte address of oInstr
oOpcode  output  7  oInstr[6:0]
oRD  output  5  oInstr[11:7]
oFunct3  output  3  oInstr[14:12]
oRS1  output  5  oInstr[19:15]
oRS2  output  5  oInstr[24:20]
oFunct7  output  7  oInstr[31:25]

Behaviour:
- Reset: iRstN is sampled on the iClk rising edge (synchronous, active low). On reset: pc=RESET_PC, rvalid=0, oValid=0, oInstr=0, oPC=0. Memory contents are untouched.
- Field outputs are combinational slices of oInstr, so all of them read 0 at reset.
- Internal state:
  - pc: address of the next read.
  - rdata / rpc / rvalid: memory read register, the PC it was read from, and its valid flag.
- advance = !oValid || iReady.
- On an advance edge with no redirect:
  - rdata <= mem[pc[log2(DEPTH)+1:2]], rpc <= pc, rvalid <= 1, pc <= pc+4.
  - oInstr <= rdata, oPC <= rpc, oValid <= rvalid.
- No advance (oValid && !iReady): pc, rdata, rpc, rvalid, oInstr, oPC and oValid all hold. The memory read is gated off, so nothing is lost or duplicated.
- Latency: the first oValid=1 appears on the 2nd rising edge after the first edge with iRstN=1. Steady-state throughput is 1 instruction per cycle while iReady=1.
- Handshake: a transfer occurs on an edge where oValid && iReady. oValid never drops without a transfer, except on redirect or reset.
- Redirect has priority over stall and over advance. On an edge with iRedirect=1:
  - pc <= {iRedirectPC[WIDTH-1:2],2'b00}, rvalid <= 0, oValid <= 0. This applies regardless of iReady; the held instruction is discarded.
  - The next edge reads the target. The target appears on oValid 2 edges after the redirect edge, giving a 2-cycle bubble.
- Wrap-around:
  - pc increments modulo 2^WIDTH.
  - The memory word index wraps modulo DEPTH, so pc=4*DEPTH reads mem[0] while oPC reports the full PC.
- Memory write:
  - mem[iWrAddr] <= iWrData on any edge with iWrEn=1, including while iRstN=0.
  - If a read and a write hit the same index on the same edge, the read returns the old data (read-before-write).
- Reset mid-operation: all state returns to reset values on that edge and oValid=0 the following cycle. Fetch restarts from RESET_PC with the same 2-edge latency.
- Simultaneous reset and redirect: reset wins.

Test Plan:
1. Hold reset; write mem[0..3]=0x00500093,0x00A00113,0x002081B3,0x40208233; release with iReady=1 -> oValid=1 on the 2nd edge after release. oPC then steps 0x0,0x4,0x8,0xC on consecutive cycles. At oPC=0x8: oOpcode=0x33, oRD=3, oRS1=1, oRS2=2, oFunct3=0, oFunct7=0x00. At oPC=0xC: oFunct7=0x20.
2. Backpressure: drop iReady for 3 cycles while oPC=0x4 -> oInstr=0x00A00113 and oPC=0x4 stay stable and oValid stays 1. Raise iReady -> 0x8 follows next cycle with no skip and no duplicate.
3. Redirect: assert iRedirect with iRedirectPC=0x22 while iReady=0 -> oValid=0 the next cycle. 2 edges after the redirect edge, oPC=0x20 and oInstr=mem[8].
4. Wrap (DEPTH=64): run sequentially past oPC=0xFC -> next output has oPC=0x100 and oInstr=mem[0].
5. Reset mid-stream: pulse iRstN low for 1 cycle at oPC=0xC -> oValid=0 and oPC=0 the next cycle. Fetch restarts at 0x0 with the preloaded memory intact.
6. Collision: write mem[2]=0xDEADBEEF on the same edge pc=0x8 is read -> oPC=0x8 shows the old 0x002081B3. A later redirect to 0x8 returns 0xDEADBEEF.
